// File: rtl/dcache_pkg.sv
// -----------------------------------------------------------------------------
// dcache_pkg
// Shared types and constants for the uncached data-side memory interface.
//   AXI_TYPE_WORD : bridge transfer-size code for a single 32-bit word
//   rd_state_t    : read engine state encoding
//   wb_entry_t    : one posted-write buffer entry (word address, strobes, data)
// -----------------------------------------------------------------------------
package dcache_pkg;

    localparam logic [2:0] AXI_TYPE_WORD = 3'b010;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_REQ  = 2'd1,
        R_DATA = 2'd2
    } rd_state_t;

    typedef struct packed {
        logic [29:0] addr;
        logic [3:0]  strb;
        logic [31:0] data;
    } wb_entry_t;

endpackage

// File: rtl/dcache_wbuf_fifo.sv
// -----------------------------------------------------------------------------
// dcache_wbuf_fifo
// Posted-write FIFO. Holds stores until the bus bridge takes them and exposes
// every entry's word address with a valid bit so loads can be checked against
// pending stores.
// Ports:
//   clock, resetn : clock, asynchronous active-low reset
//   i_push/i_entry: enqueue one entry (ignored when full)
//   i_pop         : dequeue the head entry (ignored when empty)
//   o_full/o_empty: occupancy flags from the registered count
//   o_head        : current head entry
//   o_vld/o_addrs : per-slot valid bit and word address for hazard compare
// -----------------------------------------------------------------------------
module dcache_wbuf_fifo
    import dcache_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic                    clock,
    input  logic                    resetn,
    input  logic                    i_push,
    input  wb_entry_t               i_entry,
    input  logic                    i_pop,
    output logic                    o_full,
    output logic                    o_empty,
    output wb_entry_t               o_head,
    output logic [DEPTH-1:0]        o_vld,
    output logic [DEPTH-1:0][29:0]  o_addrs
);

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic [DEPTH-1:0] r_vld;
    wb_entry_t        r_mem [DEPTH];

    logic w_push;
    logic w_pop;

    assign o_full  = (r_count == (PTR_W+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_vld    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
                r_vld[r_wr_ptr] <= 1'b1;
            end
            // Push and pop never target the same slot: a push needs a free
            // slot and a pop needs an occupied one, so when both happen the
            // pointers differ.
            if (w_pop) begin
                r_rd_ptr        <= r_rd_ptr + PTR_W'(1);
                r_vld[r_rd_ptr] <= 1'b0;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset; slots are only observed while their valid bit is set.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_entry;
        end
    end

    assign o_head = r_mem[r_rd_ptr];
    assign o_vld  = r_vld;

    always_comb begin
        o_addrs = '0;
        for (int i = 0; i < DEPTH; i++) begin
            o_addrs[i] = r_mem[i].addr;
        end
    end

endmodule

// File: rtl/dcache_wbuf.sv
// -----------------------------------------------------------------------------
// dcache_wbuf
// Uncached data-side interface between the LSU dcache port and the AXI bridge.
// Stores are posted into a write buffer and retire on acceptance; loads run
// through a single-outstanding read engine and stall while any buffered store
// targets the same word.
// Ports:
//   CPU side   : valid/ready/op/addr/awstrb/wdata, rvalid/rdata
//   Status     : wb_empty (no buffered store, nothing on the bus)
//   Read bus   : rd_req/rd_type/rd_addr/rd_rdy, ret_valid/ret_last/ret_data
//   Write bus  : wr_req/wr_type/wr_addr/wr_wstrb/wr_data/wr_rdy
// -----------------------------------------------------------------------------
module dcache_wbuf
    import dcache_pkg::*;
#(
    parameter  int WB_DEPTH = 4,
    localparam int PTR_W    = $clog2(WB_DEPTH)
) (
    input  logic         clock,
    input  logic         resetn,
    input  logic         valid,
    output logic         ready,
    input  logic         op,
    input  logic [31:0]  addr,
    input  logic [3:0]   awstrb,
    input  logic [31:0]  wdata,
    output logic         rvalid,
    output logic [31:0]  rdata,
    output logic         wb_empty,
    output logic         rd_req,
    output logic [2:0]   rd_type,
    output logic [31:0]  rd_addr,
    input  logic         rd_rdy,
    input  logic         ret_valid,
    input  logic         ret_last,
    input  logic [31:0]  ret_data,
    output logic         wr_req,
    output logic [2:0]   wr_type,
    output logic [31:0]  wr_addr,
    output logic [3:0]   wr_wstrb,
    output logic [127:0] wr_data,
    input  logic         wr_rdy
);

    rd_state_t r_state;
    rd_state_t w_state_nxt;
    logic [29:0] r_rd_addr;

    logic                       w_full;
    logic                       w_empty;
    wb_entry_t                  w_head;
    wb_entry_t                  w_entry;
    logic [WB_DEPTH-1:0]        w_vld;
    logic [WB_DEPTH-1:0][29:0]  w_addrs;
    logic                       w_hazard;
    logic                       w_wr_acc;
    logic                       w_rd_acc;
    logic                       w_pop;
    logic                       w_unused;

    assign w_unused = &{1'b0, addr[1:0]};

    assign w_entry  = '{addr: addr[31:2], strb: awstrb, data: wdata};
    // No full-bypass: a simultaneous pop does not free a slot for this cycle.
    assign w_wr_acc = valid && op && !w_full;
    assign w_rd_acc = valid && !op && (r_state == R_IDLE) && !w_hazard;
    assign w_pop    = !w_empty && wr_rdy;
    assign ready    = w_wr_acc || w_rd_acc;

    dcache_wbuf_fifo #(
        .DEPTH (WB_DEPTH),
        .PTR_W (PTR_W)
    ) u_fifo (
        .clock   (clock),
        .resetn  (resetn),
        .i_push  (w_wr_acc),
        .i_entry (w_entry),
        .i_pop   (w_pop),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (w_head),
        .o_vld   (w_vld),
        .o_addrs (w_addrs)
    );

    // A load must not overtake any buffered store to the same word.
    always_comb begin
        w_hazard = 1'b0;
        for (int i = 0; i < WB_DEPTH; i++) begin
            if (w_vld[i] && (w_addrs[i] == addr[31:2])) begin
                w_hazard = 1'b1;
            end
        end
    end

    // Read engine: state register
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= R_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clock) begin
        if (w_rd_acc) begin
            r_rd_addr <= addr[31:2];
        end
    end

    // Read engine: next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            R_IDLE:  if (w_rd_acc)              w_state_nxt = R_REQ;
            R_REQ:   if (rd_rdy)                w_state_nxt = R_DATA;
            R_DATA:  if (ret_valid && ret_last) w_state_nxt = R_IDLE;
            default:                            w_state_nxt = R_IDLE;
        endcase
    end

    // Read engine: outputs, all derived from registered state so reset clears them at once.
    always_comb begin
        rd_req = (r_state == R_REQ);
        rvalid = (r_state == R_DATA) && ret_valid && ret_last;
    end

    assign rd_type  = AXI_TYPE_WORD;
    assign rd_addr  = {r_rd_addr, 2'b00};
    assign rdata    = ret_data;

    assign wb_empty = w_empty;
    assign wr_req   = !w_empty;
    assign wr_type  = AXI_TYPE_WORD;
    assign wr_addr  = {w_head.addr, 2'b00};
    assign wr_wstrb = w_head.strb;
    assign wr_data  = {96'b0, w_head.data};

endmodule

// File: doc/dcache_wbuf.md
Name: dcache_wbuf

Overview:
- Uncached/bypass data-side memory interface with a parametrised posted write buffer and a single-outstanding read engine. Sits between the LSU's dcache port and the AXI bridge.
- CPU stores retire at buffer acceptance instead of waiting for wr_rdy.
- Loads are ordered against buffered stores by address-hazard stalling.
- Exposes buffer-empty status so barrier instructions can drain outstanding stores.

Parameters:
- WB_DEPTH, 4, write-buffer entries; power of two, at least 2.
- PTR_W, $clog2(WB_DEPTH), pointer width; derived, not overridden.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- resetn  in  1  reset; asynchronous, active-low.
- valid  in  1  CPU request valid.
- ready  out  1  CPU request accepted this cycle (valid && ready).
- op  in  1  0 read, 1 write.
- addr  in  32  byte address; bits [1:0] ignored (word-aligned internally).
- awstrb  in  4  write byte strobes.
- wdata  in  32  write data.
- rvalid  out  1  read data valid, single-cycle pulse.
- rdata  out  32  read data.
- wb_empty  out  1  write buffer empty and no write on the bus.
- rd_req  out  1  AXI bridge read request.
- rd_type  out  3  constant 3'b010 (word).
- rd_addr  out  32  word-aligned read address.
- rd_rdy  in  1  bridge accepts read request.
- ret_valid  in  1  return beat valid.
- ret_last  in  1  final return beat.
- ret_data  in  32  return data.
- wr_req  out  1  bridge write request.
- wr_type  out  3  constant 3'b010.
- wr_addr  out  32  head-entry word address.
- wr_wstrb  out  4  head-entry strobes.
- wr_data  out  128  {96'b0, head-entry data}.
- wr_rdy  in  1  bridge accepts write.

Behaviour:
- Reset (resetn low, async):
  - Write pointers and count cleared; read FSM enters R_IDLE.
  - rd_req = 0, wr_req = 0, rvalid = 0, wb_empty = 1.
  - Buffer contents are don't-care.
  - Reset mid-transfer abandons the transfer; no rvalid is produced afterwards.
- Write buffer (FIFO):
  - Entry is {addr[31:2], awstrb, wdata}.
  - Write acceptance: ready = valid && op && (count != WB_DEPTH). Accepted entry is pushed on the same posedge.
  - When full, a write is refused even if a pop occurs that cycle (no full-bypass).
- Drain:
  - wr_req = (count != 0); outputs are driven from the head entry.
  - Pop on wr_req && wr_rdy.
  - Push and pop in the same cycle leave count unchanged; pointers wrap modulo WB_DEPTH.
  - Head outputs are stable while wr_req is held without wr_rdy.
- wb_empty = (count == 0). This is combinational from registered count, so it is low in the cycle after a push.
- Read FSM states: R_IDLE, R_REQ, R_DATA.
  - R_IDLE: read acceptance is ready = valid && !op && !hazard.
    - hazard = 1 when any valid buffer entry's addr[31:2] equals addr[31:2] (comparison over all WB_DEPTH entries).
    - On acceptance, latch the word address and go to R_REQ.
  - R_REQ: rd_req = 1 and rd_addr = the latched address. On rd_rdy go to R_DATA.
  - R_DATA: rvalid = ret_valid && ret_last and rdata = ret_data. Non-last beats are ignored. On rvalid return to R_IDLE.
  - ready is 0 for reads in R_REQ and R_DATA: one outstanding read.
  - Writes may still be accepted in any read state if not full.
- Ordering:
  - A hazarded read stalls until every matching entry has drained.
  - Non-matching reads bypass buffered writes.
  - A write to the same word as an in-flight read is allowed; the read returns memory's pre-write data.
- rd_req is registered-state driven, never combinationally from valid (unlike the legacy dummy path).
- rvalid is never asserted in the same cycle as acceptance; minimum load latency is 3 cycles (accept, rd_rdy, return).

Decomposition:
- Shared package dcache_pkg holds:
  - AXI_TYPE_WORD = 3'b010
  - read FSM state encoding (R_IDLE, R_REQ, R_DATA)
  - typedef wb_entry_t {addr[31:2], strb[3:0], data[31:0]}
- Sub-module dcache_wbuf_fifo (parameter DEPTH) provides:
  - push/pop and full/empty
  - head entry
  - per-entry valid-address vector for the hazard comparator
- The top level holds the read FSM and the hazard compare.

Test Plan:
- 4 writes (0x100..0x10C, strb 4'hF) with wr_rdy = 0: all accepted back-to-back, 5th refused (ready = 0), wb_empty = 0. Then wr_rdy = 1: wr_addr sequence 0x100, 0x104, 0x108, 0x10C in order, wb_empty = 1 the cycle after the last pop.
- Write 0x200 data 0xDEADBEEF with wr_rdy = 0, then read 0x200: ready stays 0. Raise wr_rdy: read is accepted the cycle after the pop, rd_addr = 0x200.
- Write 0x300 pending, read 0x400: read accepted immediately; rd_req with rd_addr = 0x400 while wr_req is still high.
- Read 0x500 with rd_rdy delayed 3 cycles and ret_data 0x12345678 (ret_last = 1): rd_req held 3 cycles, single rvalid pulse with rdata = 0x12345678, ready returns next cycle.
- Full buffer, simultaneous write request and wr_rdy pop: write refused that cycle and accepted the next; count never exceeds 4.
- Deassert resetn during R_DATA and with 2 entries buffered: rd_req, wr_req and rvalid go low asynchronously; wb_empty = 1; no rvalid after release even if ret_valid arrives.
